mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns loads and stores into word-aligned data-memory bus transactions with a req/ack handshake, and builds byte lanes and byte enables from funct3.
- Sign- or zero-extends load data, and raises a stall to freeze the upstream pipeline until the access completes.

---
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: turns EX/MEM loads/stores into word-aligned req/ack bus
// transactions, steers byte lanes, extends load data and stalls the pipeline.
module mem_stage #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_write_m_i,
  input  logic [1:0]               result_src_m_i,
  input  logic [2:0]               funct3_m_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m_i,
  input  logic [DATA_WIDTH-1:0]    write_data_m_i,
  output logic [DATA_WIDTH-1:0]    read_data_m_o,
  output logic                     stall_m_o,
  output logic                     access_fault_o,
  output logic                     bus_err_o,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]               dmem_be_o,
  output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
  input  logic                     dmem_ack_i
);

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] raw_q, raw_d;
  logic                  err_q, err_d;

  logic                  is_store, is_load, mem_op, fault, start;
  logic [1:0]            byte_off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ext_data;

  assign is_store = mem_write_m_i;
  assign is_load  = ~mem_write_m_i & (result_src_m_i == 2'b01);
  assign mem_op   = is_store | is_load;
  assign byte_off = alu_result_m_i[1:0];

  // Illegal width codes and misaligned halfword/word addresses
  always_comb begin
    fault = 1'b0;
    case (funct3_m_i)
      3'b000:  fault = 1'b0;
      3'b001:  fault = byte_off[0];
      3'b010:  fault = (byte_off != 2'b00);
      3'b100:  fault = is_store;
      3'b101:  fault = is_store | byte_off[0];
      default: fault = 1'b1;
    endcase
  end

  assign access_fault_o = mem_op & fault;
  assign start          = rst_n & mem_op & ~fault & (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dmem_ack_i) begin
          raw_d   = dmem_rdata_i;
          state_d = S_DONE;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          raw_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      raw_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      err_q   <= err_d;
    end
  end

  // Request is asserted in the issuing IDLE cycle and held through WAIT
  assign dmem_req_o  = start | (rst_n & (state_q == S_WAIT));
  assign stall_m_o   = dmem_req_o;
  assign dmem_we_o   = is_store;
  assign bus_err_o   = (state_q == S_DONE) & err_q;
  assign dmem_addr_o = {alu_result_m_i[ADDRESS_WIDTH-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = write_data_m_i;
    if (is_store) begin
      case (funct3_m_i[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << byte_off;
          dmem_wdata_o = {4{write_data_m_i[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = byte_off[1] ? 4'b1100 : 4'b0011;
          dmem_wdata_o = {2{write_data_m_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane extraction relies on address/funct3 being frozen through DONE
  assign ld_byte = raw_q[8*byte_off +: 8];
  assign ld_half = byte_off[1] ? raw_q[31:16] : raw_q[15:0];

  always_comb begin
    case (funct3_m_i[1:0])
      2'b00:   ext_data = funct3_m_i[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ext_data = funct3_m_i[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ext_data = raw_q;
    endcase
  end

  assign read_data_m_o = (state_q == S_DONE) ? ext_data : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against an arithmetic model of the access rules.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write;
  logic [1:0]  result_src;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall, access_fault, bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_write_m_i (mem_write),
    .result_src_m_i(result_src),
    .funct3_m_i    (funct3),
    .alu_result_m_i(alu_result),
    .write_data_m_i(write_data),
    .read_data_m_o (read_data),
    .stall_m_o     (stall),
    .access_fault_o(access_fault),
    .bus_err_o     (bus_err),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_be_o     (dmem_be),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_rdata_i  (dmem_rdata),
    .dmem_ack_i    (dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected extension of a fetched word for the given width/sign code
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    int unsigned off;
    case (f3[1:0])
      2'b00: begin
        off = a % 4;
        v = (w >> (8 * off)) & 32'hFF;
        if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        off = (a % 4) / 2;
        v = (w >> (16 * off)) & 32'hFFFF;
        if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One transaction: delay = WAIT cycle index of ack; delay >= TO means no ack
  task automatic do_op(input logic st, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int delay,
                       input logic [31:0] rd);
    bit          is_op, fault, timeout;
    int unsigned size;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    @(posedge clk); #1;
    mem_write = st; result_src = rs; funct3 = f3; alu_result = a; write_data = wd;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    is_op = st || (rs == 2'b01);
    size  = 1 << f3[1:0];
    if (st) fault = (f3 > 3'd2);
    else    fault = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((a % size) != 0) fault = 1'b1;
    if (!is_op) fault = 1'b0;
    exp_be = 4'hF;
    exp_wd = wd;
    if (st && f3[1:0] == 2'b00) begin
      exp_be = 4'(1 << (a % 4));
      exp_wd = (wd & 32'hFF) * 32'h0101_0101;
    end else if (st && f3[1:0] == 2'b01) begin
      exp_be = ((a % 4) >= 2) ? 4'hC : 4'h3;
      exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
    end
    @(negedge clk);
    check_eq("fault", 32'(access_fault), 32'(fault));
    check_eq("req_issue", 32'(dmem_req), 32'(is_op && !fault));
    if (!is_op || fault) begin
      check_eq("stall_idle", 32'(stall), 0);
      check_eq("rdata_idle", read_data, 0);
      return;
    end
    check_eq("stall_issue", 32'(stall), 1);
    check_eq("addr", dmem_addr, a & 32'hFFFF_FFFC);
    check_eq("we", 32'(dmem_we), 32'(st));
    check_eq("be", 32'(dmem_be), 32'(exp_be));
    if (st) check_eq("wdata", dmem_wdata, exp_wd);
    for (int i = 0; i < int'(TO); i++) begin
      @(posedge clk); #1;
      dmem_ack   = (i == delay);
      dmem_rdata = dmem_ack ? rd : $urandom;
      @(negedge clk);
      check_eq("stall_wait", 32'(stall), 1);
      check_eq("req_wait", 32'(dmem_req), 1);
      if (i == delay) break;
    end
    timeout = (delay >= int'(TO));
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    check_eq("req_done", 32'(dmem_req), 0);
    check_eq("stall_done", 32'(stall), 0);
    check_eq("bus_err", 32'(bus_err), 32'(timeout));
    check_eq("rdata_done", read_data, timeout ? 32'h0 : model_load(f3, a, rd));
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic [31:0] a;
    int          kind;
    rst_n = 1'b0; mem_write = 1'b0; result_src = 2'b00; funct3 = 3'b000;
    alu_result = '0; write_data = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    #12;
    check_eq("rst_req", 32'(dmem_req), 0);
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_rdata", read_data, 0);
    check_eq("rst_buserr", 32'(bus_err), 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1'b0, 2'b01, 3'b010, 32'h0000_1008, 32'h0, 0, 32'hDEAD_BEEF);
    do_op(1'b0, 2'b01, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000);
    do_op(1'b0, 2'b01, 3'b100, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000);
    do_op(1'b1, 2'b00, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 1, 32'h0);
    do_op(1'b0, 2'b01, 3'b010, 32'h0000_1006, 32'h0, 0, 32'h0);
    do_op(1'b1, 2'b00, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, TO, 32'h0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rs   = 2'($urandom_range(0, 3));
      if (rs == 2'b01) rs = 2'b10;
      if ($urandom_range(0, 6) == 0) f3 = 3'($urandom_range(0, 7));
      else if (kind >= 5) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << f3[1:0]) - 32'h1);
      case (kind)
        0:       do_op(1'b0, rs, f3, a, $urandom, 0, $urandom);
        1, 2, 3, 4:
                 do_op(1'b0, 2'b01, f3, a, $urandom, $urandom_range(0, 5), $urandom);
        9:       do_op(1'b1, 2'b01, f3, a, $urandom, $urandom_range(0, 5), $urandom);
        default: do_op(1'b1, rs, f3, a, $urandom, $urandom_range(0, 5), $urandom);
      endcase
    end

    // Reset in the middle of WAIT, with a late ack arriving afterwards
    @(posedge clk); #1;
    mem_write = 1'b0; result_src = 2'b01; funct3 = 3'b010; alu_result = 32'h0000_4000;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_wait_stall", 32'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_req_drop", 32'(dmem_req), 0);
    check_eq("rst_stall_drop", 32'(stall), 0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    result_src = 2'b00; rst_n = 1'b1;
    @(negedge clk);
    check_eq("late_ack_req", 32'(dmem_req), 0);
    check_eq("late_ack_stall", 32'(stall), 0);
    check_eq("late_ack_rdata", read_data, 0);
    check_eq("late_ack_buserr", 32'(bus_err), 0);
    @(posedge clk); #1 dmem_ack = 1'b0;
    do_op(1'b0, 2'b01, 3'b101, 32'h0000_5002, 32'h0, 2, 32'h8001_7FFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
